// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the receive framer state type.
// Also used by the transmit side, which shares crc32_d8.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    // FCS is four bytes, so one payload byte must trail behind it
    localparam int DLY_DEPTH = 5;

    typedef enum logic [1:0] {
        DROP,
        IDLE,
        PRE,
        DATA
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 advance by one byte, bits taken LSB first.
// The register is kept un-reflected, so a clean frame leaves CRC32_RESIDUE behind.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = {crc_out[30:0], 1'b0} ^ ((crc_out[31] ^ data[i]) ? CRC32_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/eth_rx_framer.sv
// Receive framer: strips preamble/SFD, delays payload by the FCS length so the
// FCS can be dropped, and tags the final byte with a CRC/length/error verdict.
module eth_rx_framer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 16
) (
    input  logic             ETH_RX_CLK,
    input  logic             ETH_RX_RSTN,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_DV,
    input  logic             RX_ER,
    output logic [7:0]       OUT_DATA,
    output logic             OUT_VALID,
    output logic             OUT_LAST,
    output logic             OUT_OK,
    output logic [CNT_W-1:0] FRAME_OK_CNT,
    output logic [CNT_W-1:0] FRAME_ERR_CNT
);

    localparam int LEN_W = $clog2(MAX_FRAME + 1) + 1;

    rx_state_e                      state;
    rx_state_e                      state_nxt;
    logic [LEN_W-1:0]               len;
    logic [DLY_DEPTH-1:0][7:0]      dly;
    logic [31:0]                    crc;
    logic [31:0]                    crc_nxt;
    logic                           err_flag;

    logic                           start_frame;
    logic                           accept;
    logic                           emit;
    logic                           emit_last;
    logic                           verdict_ok;
    logic                           inc_ok;
    logic                           inc_err;
    logic                           line_full;

    assign line_full = (len >= LEN_W'(DLY_DEPTH));

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (RX_DATA),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge ETH_RX_CLK or negedge ETH_RX_RSTN) begin
        if (!ETH_RX_RSTN) begin
            state <= DROP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        accept      = 1'b0;
        emit        = 1'b0;
        emit_last   = 1'b0;
        verdict_ok  = 1'b0;
        inc_ok      = 1'b0;
        inc_err     = 1'b0;
        case (state)
            DROP: begin
                if (!RX_DV) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (RX_DV) begin
                    if (RX_DATA == PREAMBLE_BYTE) begin
                        state_nxt = PRE;
                    end else begin
                        state_nxt = DROP;
                        inc_err   = 1'b1;
                    end
                end
            end
            PRE: begin
                if (!RX_DV) begin
                    state_nxt = IDLE;
                end else if (RX_DATA == SFD_BYTE) begin
                    state_nxt   = DATA;
                    start_frame = 1'b1;
                end else if (RX_DATA != PREAMBLE_BYTE) begin
                    state_nxt = DROP;
                    inc_err   = 1'b1;
                end
            end
            DATA: begin
                if (RX_DV) begin
                    // Oversize: close the frame now as bad and ignore the rest
                    if (len == LEN_W'(MAX_FRAME)) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        inc_err   = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        accept = 1'b1;
                        emit   = line_full;
                    end
                end else begin
                    state_nxt  = IDLE;
                    emit       = line_full;
                    emit_last  = line_full;
                    verdict_ok = line_full && (crc == CRC32_RESIDUE) && !err_flag &&
                                 (len >= LEN_W'(MIN_FRAME)) && (len <= LEN_W'(MAX_FRAME));
                    inc_ok     = verdict_ok;
                    inc_err    = !verdict_ok;
                end
            end
            default: state_nxt = DROP;
        endcase
    end

    always_ff @(posedge ETH_RX_CLK or negedge ETH_RX_RSTN) begin
        if (!ETH_RX_RSTN) begin
            OUT_DATA      <= '0;
            OUT_VALID     <= 1'b0;
            OUT_LAST      <= 1'b0;
            OUT_OK        <= 1'b0;
            FRAME_OK_CNT  <= '0;
            FRAME_ERR_CNT <= '0;
            len           <= '0;
            dly           <= '0;
            crc           <= CRC32_INIT;
            err_flag      <= 1'b0;
        end else begin
            OUT_VALID <= emit;
            OUT_LAST  <= emit_last;
            OUT_OK    <= emit_last && verdict_ok;
            if (emit) begin
                OUT_DATA <= dly[DLY_DEPTH-1];
            end
            FRAME_OK_CNT  <= FRAME_OK_CNT + CNT_W'(inc_ok);
            FRAME_ERR_CNT <= FRAME_ERR_CNT + CNT_W'(inc_err);
            if (start_frame) begin
                crc      <= CRC32_INIT;
                len      <= '0;
                err_flag <= 1'b0;
            end else if (accept) begin
                crc      <= crc_nxt;
                err_flag <= err_flag | RX_ER;
                dly      <= {dly[DLY_DEPTH-2:0], RX_DATA};
                if (len != '1) begin
                    len <= len + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Bench for eth_rx_framer: directed frame table, hand-built reset/back-to-back
// sequences and random frames, all scored against a frame-level reference model.
module tb_eth_rx_framer;

    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_dv = 1'b0;
    logic             rx_er = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ok;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;

    eth_rx_framer #(
        .MIN_FRAME (MIN_FRAME),
        .MAX_FRAME (MAX_FRAME),
        .CNT_W     (CNT_W)
    ) dut (
        .ETH_RX_CLK    (clk),
        .ETH_RX_RSTN   (rst_n),
        .RX_DATA       (rx_data),
        .RX_DV         (rx_dv),
        .RX_ER         (rx_er),
        .OUT_DATA      (out_data),
        .OUT_VALID     (out_valid),
        .OUT_LAST      (out_last),
        .OUT_OK        (out_ok),
        .FRAME_OK_CNT  (ok_cnt),
        .FRAME_ERR_CNT (err_cnt)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       ok;
    } ev_t;

    typedef struct {
        string      name;
        int         pre_len;
        logic [7:0] sfd;
        int         n_pay;
        bit         fcs;
        int         flip_idx;
        int         er_idx;
        int         nout;
        int         nlast;
        bit         ok;
        int         dok;
        int         derr;
    } vec_t;

    ev_t              got_q[$];
    ev_t              exp_q[$];
    logic [7:0]       tx_q[$];
    int               compared = 0;
    int               mismatched = 0;
    int               cyc = 0;
    int               da_cyc = -1;
    int               got_first_cyc = -1;
    int               stray_last = 0;
    logic [CNT_W-1:0] exp_ok_cnt = '0;
    logic [CNT_W-1:0] exp_err_cnt = '0;
    vec_t             vecs[13];
    vec_t             none_vec;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every emitted byte; the verdict is only meaningful on the last one
    always @(negedge clk) begin
        if (out_last && !out_valid) stray_last++;
        if (out_valid) begin
            if (got_first_cyc < 0) got_first_cyc = cyc;
            got_q.push_back('{out_data, out_last, out_last ? out_ok : 1'b0});
        end
    end

    task automatic checkValue(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveCycle(input logic dv, input logic [7:0] d, input logic er);
        @(negedge clk);
        rx_dv   = dv;
        rx_data = d;
        rx_er   = er;
    endtask

    // Plain IEEE 802.3 CRC-32 over the first n queued bytes, as it goes on the wire
    function automatic logic [31:0] crc32Ref(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, tx_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic appendFcs();
        logic [31:0] c = crc32Ref(tx_q.size());
        for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
    endtask

    task automatic buildPayload(input int n, input bit rnd);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    task automatic modelFrame(input int pre_len, input logic [7:0] sfd, input int er_idx);
        int         len = tx_q.size();
        int         n_out = 0;
        bit         good = 1'b0;
        logic [31:0] fcs_rx;
        if (pre_len < 1 || sfd != 8'hD5) begin
            exp_err_cnt++;
        end else if (len > MAX_FRAME) begin
            n_out = MAX_FRAME - 4;
            exp_err_cnt++;
        end else if (len < 5) begin
            exp_err_cnt++;
        end else begin
            n_out  = len - 4;
            fcs_rx = {tx_q[len-1], tx_q[len-2], tx_q[len-3], tx_q[len-4]};
            good   = (crc32Ref(len - 4) == fcs_rx) && (len >= MIN_FRAME) &&
                     !(er_idx >= 0 && er_idx < len);
            if (good) exp_ok_cnt++;
            else      exp_err_cnt++;
        end
        for (int i = 0; i < n_out; i++)
            exp_q.push_back('{tx_q[i], i == n_out - 1, (i == n_out - 1) && good});
    endtask

    task automatic applyStimulus(input int pre_len, input logic [7:0] sfd, input int er_idx, input int gap);
        for (int i = 0; i < pre_len; i++) driveCycle(1'b1, 8'h55, 1'b0);
        driveCycle(1'b1, sfd, 1'b0);
        for (int i = 0; i < tx_q.size(); i++) begin
            driveCycle(1'b1, tx_q[i], i == er_idx);
            if (i == 0 && da_cyc < 0) da_cyc = cyc + 1;
        end
        for (int i = 0; i < gap; i++) driveCycle(1'b0, 8'h00, 1'b0);
        modelFrame(pre_len, sfd, er_idx);
    endtask

    task automatic checkOutput(input string name, input bit use_tbl, input vec_t tc,
                               input logic [CNT_W-1:0] ok_base, input logic [CNT_W-1:0] err_base);
        int mism = 0;
        int nlast = 0;
        int last_ok = 0;
        repeat (2) @(negedge clk);
        #1;
        checkValue({name, " byte count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last ||
                got_q[i].ok !== exp_q[i].ok) mism++;
        checkValue({name, " bad events"}, mism, 0);
        checkValue({name, " ok count"}, ok_cnt, exp_ok_cnt);
        checkValue({name, " err count"}, err_cnt, exp_err_cnt);
        checkValue({name, " stray last"}, stray_last, 0);
        if (exp_q.size() > 0 && got_q.size() > 0)
            checkValue({name, " latency"}, got_first_cyc - da_cyc, 5);
        if (use_tbl) begin
            foreach (got_q[i]) if (got_q[i].last) begin nlast++; last_ok = got_q[i].ok; end
            checkValue({name, " tbl nout"}, got_q.size(), tc.nout);
            checkValue({name, " tbl nlast"}, nlast, tc.nlast);
            if (tc.nlast > 0) checkValue({name, " tbl ok"}, last_ok, tc.ok);
            checkValue({name, " tbl dok"}, CNT_W'(ok_cnt - ok_base), tc.dok);
            checkValue({name, " tbl derr"}, CNT_W'(err_cnt - err_base), tc.derr);
        end
        got_q.delete();
        exp_q.delete();
        da_cyc        = -1;
        got_first_cyc = -1;
    endtask

    initial begin
        #5ms;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        logic [CNT_W-1:0] ok_base;
        logic [CNT_W-1:0] err_base;
        int               n;

        vecs[0]  = '{"good64",   7, 8'hD5,   60, 1, -1, -1,   60, 1, 1, 1, 0};
        vecs[1]  = '{"bitflip",  7, 8'hD5,   60, 1, 20, -1,   60, 1, 0, 0, 1};
        vecs[2]  = '{"rxer10",   7, 8'hD5,   60, 1, -1, 10,   60, 1, 0, 0, 1};
        vecs[3]  = '{"short40",  7, 8'hD5,   36, 1, -1, -1,   36, 1, 0, 0, 1};
        vecs[4]  = '{"runt3",    7, 8'hD5,    3, 0, -1, -1,    0, 0, 0, 0, 1};
        vecs[5]  = '{"runt4",    7, 8'hD5,    0, 1, -1, -1,    0, 0, 0, 0, 1};
        vecs[6]  = '{"len5",     7, 8'hD5,    1, 1, -1, -1,    1, 1, 0, 0, 1};
        vecs[7]  = '{"max1518",  7, 8'hD5, 1514, 1, -1, -1, 1514, 1, 1, 1, 0};
        vecs[8]  = '{"over1519", 7, 8'hD5, 1515, 1, -1, -1, 1514, 1, 0, 0, 1};
        vecs[9]  = '{"over1600", 7, 8'hD5, 1596, 1, -1, -1, 1514, 1, 0, 0, 1};
        vecs[10] = '{"badsfd",   7, 8'h57,   60, 1, -1, -1,    0, 0, 0, 0, 1};
        vecs[11] = '{"nopre",    0, 8'hD5,   60, 1, -1, -1,    0, 0, 0, 0, 1};
        vecs[12] = '{"pre1",     1, 8'hD5,   60, 1, -1, -1,   60, 1, 1, 1, 0};
        none_vec = vecs[0];

        // Reset values, then release reset in the middle of a frame
        repeat (3) driveCycle(1'b0, 8'h00, 1'b0);
        #1;
        checkValue("reset valid", out_valid, 0);
        checkValue("reset last", out_last, 0);
        checkValue("reset ok", out_ok, 0);
        checkValue("reset data", out_data, 0);
        checkValue("reset okcnt", ok_cnt, 0);
        checkValue("reset errcnt", err_cnt, 0);
        for (int i = 0; i < 7; i++) driveCycle(1'b1, 8'h55, 1'b0);
        driveCycle(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 50; i++) begin
            driveCycle(1'b1, 8'(i), 1'b0);
            if (i == 10) rst_n = 1'b1;
        end
        driveCycle(1'b0, 8'h00, 1'b0);
        checkOutput("rst_release", 1'b0, none_vec, exp_ok_cnt, exp_err_cnt);

        for (int v = 0; v < 13; v++) begin
            buildPayload(vecs[v].n_pay, 1'b0);
            if (vecs[v].fcs) appendFcs();
            if (vecs[v].flip_idx >= 0) tx_q[vecs[v].flip_idx] ^= 8'h04;
            ok_base  = exp_ok_cnt;
            err_base = exp_err_cnt;
            applyStimulus(vecs[v].pre_len, vecs[v].sfd, vecs[v].er_idx, 2);
            checkOutput(vecs[v].name, 1'b1, vecs[v], ok_base, err_base);
        end

        // Preamble cut short by DV falling is silently discarded
        for (int i = 0; i < 5; i++) driveCycle(1'b1, 8'h55, 1'b0);
        driveCycle(1'b0, 8'h00, 1'b0);
        checkOutput("pre_abort", 1'b0, none_vec, exp_ok_cnt, exp_err_cnt);

        // Two good minimum frames separated by a single idle cycle
        buildPayload(60, 1'b1);
        appendFcs();
        applyStimulus(7, 8'hD5, -1, 1);
        buildPayload(60, 1'b1);
        appendFcs();
        applyStimulus(7, 8'hD5, -1, 1);
        checkOutput("back2back", 1'b0, none_vec, exp_ok_cnt, exp_err_cnt);

        // Reset pulled mid-frame clears outputs and counters without waiting for a clock
        for (int i = 0; i < 7; i++) driveCycle(1'b1, 8'h55, 1'b0);
        driveCycle(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) driveCycle(1'b1, 8'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async valid", out_valid, 0);
        checkValue("async okcnt", ok_cnt, 0);
        checkValue("async errcnt", err_cnt, 0);
        got_q.delete();
        got_first_cyc = -1;
        exp_ok_cnt    = '0;
        exp_err_cnt   = '0;
        for (int i = 0; i < 20; i++) begin
            driveCycle(1'b1, 8'(i + 30), 1'b0);
            if (i == 2) rst_n = 1'b1;
        end
        driveCycle(1'b0, 8'h00, 1'b0);
        checkOutput("async_rst", 1'b0, none_vec, exp_ok_cnt, exp_err_cnt);

        buildPayload(70, 1'b1);
        appendFcs();
        applyStimulus(7, 8'hD5, -1, 2);
        checkOutput("post_rst", 1'b0, none_vec, exp_ok_cnt, exp_err_cnt);

        // Random frames: lengths around the runt/minimum limits, corruption and errors
        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 120);
            buildPayload(n, 1'b1);
            if ($urandom_range(0, 99) < 85) appendFcs();
            if (n > 0 && $urandom_range(0, 99) < 15)
                tx_q[$urandom_range(0, n - 1)] ^= 8'(1 << $urandom_range(0, 7));
            applyStimulus($urandom_range(1, 8), 8'hD5,
                          ($urandom_range(0, 9) == 0 && tx_q.size() > 0) ?
                              int'($urandom_range(0, tx_q.size() - 1)) : -1,
                          $urandom_range(1, 3));
            checkOutput($sformatf("rand%0d", r), 1'b0, none_vec, exp_ok_cnt, exp_err_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/eth_rx_framer.md
Name: eth_rx_framer

Overview:
- Sits directly downstream of the RGMII receive capture in top, which delivers one demuxed byte per ETH_RX_CLK (125 MHz) with DV/ER flags.
- Strips preamble and SFD, checks length and CRC-32, and removes the 4-byte FCS.
- Emits payload bytes (DA through last data byte) with a LAST marker and a good/bad verdict, feeding the frame FIFO that drains to the UART side.
- Ethernet cannot be stalled, so the output has no backpressure.

Parameters:
- MIN_FRAME, 64: minimum legal length in bytes, DA..FCS inclusive.
- MAX_FRAME, 1518: maximum legal length in bytes, DA..FCS inclusive.
- CNT_W, 16: width of the statistics counters.

Ports:
- ETH_RX_CLK  in  1  receive clock, 125 MHz; the only clock.
- ETH_RX_RSTN  in  1  reset, asynchronous, active-low.
- RX_DATA  in  8  received byte.
- RX_DV  in  1  data valid (RX_CTL rising-edge half).
- RX_ER  in  1  receive error (DV xor falling-edge CTL).
- OUT_DATA  out  8  payload byte.
- OUT_VALID  out  1  OUT_DATA valid this cycle.
- OUT_LAST  out  1  final byte of the frame; only asserted together with OUT_VALID.
- OUT_OK  out  1  frame verdict; meaningful only while OUT_LAST=1.
- FRAME_OK_CNT  out  CNT_W  count of good frames, wraps.
- FRAME_ERR_CNT  out  CNT_W  count of bad, runt and dropped frames, wraps.

Behaviour:
- Reset values: all outputs 0; state DROP; pipeline empty; CRC register 0xFFFFFFFF.
- Reset state is DROP, so a frame already in progress at reset release is never picked up.
- States:
  - DROP: stay while RX_DV=1; go to IDLE on RX_DV=0.
  - IDLE:
    - RX_DV=1 and RX_DATA=0x55 -> PRE.
    - RX_DV=1 with any other byte -> DROP, FRAME_ERR_CNT+1.
  - PRE:
    - 0x55 -> stay.
    - 0xD5 -> DATA; CRC preset to 0xFFFFFFFF; length counter cleared.
    - Any other byte -> DROP, FRAME_ERR_CNT+1.
    - RX_DV=0 -> IDLE, not counted.
  - DATA, while RX_DV=1:
    - Shift the byte into a 5-deep delay line.
    - Update the CRC (reflected, poly 0x04C11DB7) over every byte including the FCS.
    - Length counter +1, saturating.
    - RX_ER=1 sets the sticky err flag.
- Output during DATA: once the delay line holds 5 bytes, each new input byte pushes the oldest byte out with OUT_VALID=1 and OUT_LAST=0. Input-to-output latency is 5 byte-cycles.
- End of frame (first cycle with RX_DV=0 in DATA):
  - If length>=5, the oldest remaining byte (last payload byte) is emitted with OUT_VALID=1 and OUT_LAST=1. The 4 FCS bytes are discarded.
  - OUT_OK=1 iff all of: CRC register==0xC704DD7B (un-inverted residue), MIN_FRAME<=length<=MAX_FRAME, err flag=0.
  - OUT_OK=1 increments FRAME_OK_CNT; otherwise FRAME_ERR_CNT increments.
  - Next state IDLE.
- Runt: length<5 at DV fall -> no output bytes at all, FRAME_ERR_CNT+1, -> IDLE.
- Oversize: in the cycle length would exceed MAX_FRAME:
  - Emit the oldest byte with OUT_LAST=1, OUT_OK=0.
  - FRAME_ERR_CNT+1, -> DROP.
- Only one LAST is ever emitted per frame.
- Back-to-back frames need at least one RX_DV=0 cycle between them (the IFG guarantees this). The DV-fall cycle both closes the frame and returns the block to IDLE.
- Asserting ETH_RX_RSTN low mid-frame clears everything immediately. No LAST is emitted, so the downstream FIFO must also be reset.
- Counters wrap at 2^CNT_W.

Decomposition:
- Package eth_pkg holds:
  - PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5.
  - CRC32_POLY=0x04C11DB7, CRC32_INIT=0xFFFFFFFF, CRC32_RESIDUE=0xC704DD7B.
  - The framer state enum {DROP, IDLE, PRE, DATA}.
- One sub-module, crc32_d8: combinational next-CRC for one byte, given the current CRC and the data byte. The same function is reused by tx_phy for FCS generation.

Test Plan:
- Reset release while RX_DV=1 mid-frame -> no OUT_VALID until DV drops. The next clean frame is received normally.
- 7x0x55, 0xD5, then 60 bytes 0x00..0x3B plus a correct FCS (bench model) ->
  - 60 OUT_VALID bytes 0x00..0x3B; the first appears 5 cycles after the first DA byte.
  - OUT_LAST on 0x3B with OUT_OK=1.
  - FRAME_OK_CNT=1.
- Same frame with one payload bit flipped, and separately with RX_ER=1 on byte 10 -> OUT_LAST with OUT_OK=0; FRAME_ERR_CNT increments each time.
- 40-byte frame with correct FCS -> 36 bytes out, OUT_OK=0 (below MIN_FRAME). A 3-byte frame -> no output, FRAME_ERR_CNT+1.
- 1600-byte frame -> exactly one OUT_LAST, OUT_OK=0, at input byte 1519. No further OUT_VALID until the next frame.
- Two good 64-byte frames separated by 1 idle cycle -> both delivered, FRAME_OK_CNT=2. Also bad SFD 0x57 -> nothing emitted, FRAME_ERR_CNT+1.
